// File: rtl/execute_result_buffer_pkg.sv
// Shared control enums for the execute result buffer.
// XLEN normally comes from parameters.svh; it falls back to 32 when that file is not part of the build.
`ifndef XLEN
`define XLEN 32
`endif

package HighLevelControl;

    // Encodings follow the RISC-V funct3 field, so 3'b010 and 3'b011 are undefined.
    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } branchOperation;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } bufferState;

endpackage

// File: rtl/execute_result_buffer_branch_evaluator.sv
// Combinational branch condition: ALU flags plus branch operation give the taken bit.
// Carry=1 means an unsigned borrow on the compare subtraction.
module branchEvaluator
    import HighLevelControl::*;
(
    input  logic           zero,
    input  logic           overflow,
    input  logic           negative,
    input  logic           carry,
    input  branchOperation op,
    output logic           taken
);

    always_comb begin
        taken = 1'b0;
        case (op)
            BEQ:     taken = zero;
            BNE:     taken = ~zero;
            BLT:     taken = negative ^ overflow;
            BGE:     taken = ~(negative ^ overflow);
            BLTU:    taken = carry;
            BGEU:    taken = ~carry;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/execute_result_buffer.sv
// Two-entry skid buffer between the ALU and writeback; all outputs are registered.
// Define BRANCH_EVAL_EN to evaluate and carry a branch-taken bit with each entry.
//
// state | meaning
// EMPTY | no entries held, OutValid=0, InReady=1
// ONE   | head entry on Out*, InReady=1
// FULL  | head on Out*, second entry in tail, InReady=0
module execute_result_buffer
    import HighLevelControl::*;
#(
    parameter int RD_WIDTH = 5
)
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                InValid,
    output logic                InReady,
    input  logic [`XLEN-1:0]    AluResult,
    input  logic                Zero,
    input  logic                oVerflow,
    input  logic                Negative,
    input  logic                Carry,
    input  logic [RD_WIDTH-1:0] InRd,
    input  logic                InRegWrite,
    input  logic                InIsBranch,
    input  branchOperation      InBranchOp,
    input  logic                Flush,
    output logic                OutValid,
    input  logic                OutReady,
    output logic [`XLEN-1:0]    OutResult,
    output logic [RD_WIDTH-1:0] OutRd,
    output logic                OutRegWrite,
    output logic                OutBranchTaken
);

    bufferState          state;
    logic [`XLEN-1:0]    tail_result;
    logic [RD_WIDTH-1:0] tail_rd;
    logic                tail_regwrite;
    logic                push;
    logic                pop;

    assign push = InValid & InReady & ~Flush;
    assign pop  = OutValid & OutReady & ~Flush;

`ifdef BRANCH_EVAL_EN
    logic eval_taken;
    logic in_taken;
    logic tail_taken;

    branchEvaluator u_branch_evaluator (
        .zero     (Zero),
        .overflow (oVerflow),
        .negative (Negative),
        .carry    (Carry),
        .op       (InBranchOp),
        .taken    (eval_taken)
    );

    assign in_taken = InIsBranch & eval_taken;
`else
    logic unused_branch_inputs;
    assign unused_branch_inputs = ^{InIsBranch, InBranchOp, Zero, oVerflow, Negative, Carry};
    assign OutBranchTaken = 1'b0;
`endif

    // Head entry lives directly in the Out* registers; flags are cleared whenever OutValid drops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= EMPTY;
            InReady       <= 1'b1;
            OutValid      <= 1'b0;
            OutResult     <= '0;
            OutRd         <= '0;
            OutRegWrite   <= 1'b0;
            tail_result   <= '0;
            tail_rd       <= '0;
            tail_regwrite <= 1'b0;
`ifdef BRANCH_EVAL_EN
            OutBranchTaken <= 1'b0;
            tail_taken     <= 1'b0;
`endif
        end else if (Flush) begin
            state       <= EMPTY;
            InReady     <= 1'b1;
            OutValid    <= 1'b0;
            OutRegWrite <= 1'b0;
`ifdef BRANCH_EVAL_EN
            OutBranchTaken <= 1'b0;
`endif
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        state       <= ONE;
                        OutValid    <= 1'b1;
                        OutResult   <= AluResult;
                        OutRd       <= InRd;
                        OutRegWrite <= InRegWrite;
`ifdef BRANCH_EVAL_EN
                        OutBranchTaken <= in_taken;
`endif
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        OutResult   <= AluResult;
                        OutRd       <= InRd;
                        OutRegWrite <= InRegWrite;
`ifdef BRANCH_EVAL_EN
                        OutBranchTaken <= in_taken;
`endif
                    end else if (push) begin
                        state         <= FULL;
                        InReady       <= 1'b0;
                        tail_result   <= AluResult;
                        tail_rd       <= InRd;
                        tail_regwrite <= InRegWrite;
`ifdef BRANCH_EVAL_EN
                        tail_taken <= in_taken;
`endif
                    end else if (pop) begin
                        state       <= EMPTY;
                        OutValid    <= 1'b0;
                        OutRegWrite <= 1'b0;
`ifdef BRANCH_EVAL_EN
                        OutBranchTaken <= 1'b0;
`endif
                    end
                end
                FULL: begin
                    if (pop) begin
                        state       <= ONE;
                        InReady     <= 1'b1;
                        OutResult   <= tail_result;
                        OutRd       <= tail_rd;
                        OutRegWrite <= tail_regwrite;
`ifdef BRANCH_EVAL_EN
                        OutBranchTaken <= tail_taken;
`endif
                    end
                end
                default: begin
                    state       <= EMPTY;
                    InReady     <= 1'b1;
                    OutValid    <= 1'b0;
                    OutRegWrite <= 1'b0;
`ifdef BRANCH_EVAL_EN
                    OutBranchTaken <= 1'b0;
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_execute_result_buffer.sv
// Self-checking bench for execute_result_buffer: directed sequences, a branch vector table,
// and randomized traffic against a queue-based reference model.
`ifndef XLEN
`define XLEN 32
`endif

module tb_execute_result_buffer;
    import HighLevelControl::*;

    localparam int RDW = 5;

    logic               clk;
    logic               reset_n;
    logic               InValid;
    logic               InReady;
    logic [`XLEN-1:0]   AluResult;
    logic               Zero, oVerflow, Negative, Carry;
    logic [RDW-1:0]     InRd;
    logic               InRegWrite;
    logic               InIsBranch;
    branchOperation     InBranchOp;
    logic               Flush;
    logic               OutValid;
    logic               OutReady;
    logic [`XLEN-1:0]   OutResult;
    logic [RDW-1:0]     OutRd;
    logic               OutRegWrite;
    logic               OutBranchTaken;

    int checks   = 0;
    int failures = 0;

    execute_result_buffer #(.RD_WIDTH(RDW)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .InValid        (InValid),
        .InReady        (InReady),
        .AluResult      (AluResult),
        .Zero           (Zero),
        .oVerflow       (oVerflow),
        .Negative       (Negative),
        .Carry          (Carry),
        .InRd           (InRd),
        .InRegWrite     (InRegWrite),
        .InIsBranch     (InIsBranch),
        .InBranchOp     (InBranchOp),
        .Flush          (Flush),
        .OutValid       (OutValid),
        .OutReady       (OutReady),
        .OutResult      (OutResult),
        .OutRd          (OutRd),
        .OutRegWrite    (OutRegWrite),
        .OutBranchTaken (OutBranchTaken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [`XLEN-1:0] result;
        logic [RDW-1:0]   rd;
        logic             rw;
        logic             taken;
    } entry_t;

    typedef struct {
        logic             isb;
        logic [2:0]       op;
        logic             z, v, n, c;
        logic             taken_on;
        logic [31:0]      data;
    } bvec_t;

    entry_t q[$];
    bvec_t  tbl[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic model_taken(input logic isb, input branchOperation op,
                                         input logic z, input logic v, input logic n, input logic c);
`ifdef BRANCH_EVAL_EN
        if (!isb) return 1'b0;
        case (op)
            BEQ:     return z;
            BNE:     return !z;
            BLT:     return n != v;
            BGE:     return n == v;
            BLTU:    return c;
            BGEU:    return !c;
            default: return 1'b0;
        endcase
`else
        return 1'b0;
`endif
    endfunction

    task automatic fill2(input logic [`XLEN-1:0] a, input logic [`XLEN-1:0] b);
        OutReady   = 1'b0;
        InValid    = 1'b1;
        InRegWrite = 1'b1;
        AluResult  = a;
        cycle();
        AluResult  = b;
        cycle();
        InValid    = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{1'b1, BLT,    1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h11};
        tbl[1] = '{1'b1, BLTU,   1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h12};
        tbl[2] = '{1'b1, BNE,    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h13};
        tbl[3] = '{1'b1, BEQ,    1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h14};
        tbl[4] = '{1'b1, BGE,    1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h15};
        tbl[5] = '{1'b1, BGEU,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h16};
        tbl[6] = '{1'b1, 3'b010, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h17};
        tbl[7] = '{1'b0, BEQ,    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h18};
        tbl[8] = '{1'b1, BLT,    1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h19};

        reset_n = 1'b0;
        InValid = 1'b0; AluResult = '0; InRd = '0; InRegWrite = 1'b0;
        InIsBranch = 1'b0; InBranchOp = BEQ; Flush = 1'b0; OutReady = 1'b0;
        Zero = 1'b0; oVerflow = 1'b0; Negative = 1'b0; Carry = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_outvalid", OutValid, 0);
        chk("rst_inready", InReady, 1);
        chk("rst_result", OutResult, 0);
        chk("rst_rd", OutRd, 0);
        chk("rst_regwrite", OutRegWrite, 0);
        chk("rst_taken", OutBranchTaken, 0);
        reset_n = 1'b1;
        cycle();

        // Backpressure: A and B fill the buffer, C is refused.
        OutReady = 1'b0; InValid = 1'b1; InRegWrite = 1'b1;
        AluResult = `XLEN'('hA); InRd = 5'd1;
        cycle();
        chk("bp_valid_a", OutValid, 1);
        chk("bp_result_a", OutResult, 'hA);
        chk("bp_ready_one", InReady, 1);
        AluResult = `XLEN'('hB); InRd = 5'd2;
        cycle();
        chk("bp_ready_full", InReady, 0);
        chk("bp_hold_a", OutResult, 'hA);
        AluResult = `XLEN'('hC); InRd = 5'd3;
        cycle();
        chk("bp_still_full", InReady, 0);
        chk("bp_stable_a", OutResult, 'hA);
        chk("bp_stable_rd", OutRd, 1);
        InValid = 1'b0; OutReady = 1'b1;
        cycle();
        chk("bp_result_b", OutResult, 'hB);
        chk("bp_rd_b", OutRd, 2);
        chk("bp_valid_b", OutValid, 1);
        chk("bp_ready_after", InReady, 1);
        cycle();
        chk("bp_drained", OutValid, 0);
        chk("bp_drained_rw", OutRegWrite, 0);

        // Streaming with OutReady held high: one-cycle latency, no bubbles.
        OutReady = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            InValid = 1'b1; AluResult = `XLEN'(i); InRd = RDW'(i);
            cycle();
            chk("st_valid", OutValid, 1);
            chk("st_result", OutResult, i);
            chk("st_ready", InReady, 1);
        end
        InValid = 1'b0;
        cycle();
        chk("st_end", OutValid, 0);

        // Flush while FULL with a pending push.
        fill2(`XLEN'(1), `XLEN'(2));
        chk("fl_full", InReady, 0);
        Flush = 1'b1; InValid = 1'b1; AluResult = `XLEN'(3);
        cycle();
        Flush = 1'b0; InValid = 1'b0;
        chk("fl_valid", OutValid, 0);
        chk("fl_ready", InReady, 1);
        chk("fl_rw", OutRegWrite, 0);
        OutReady = 1'b1;
        cycle();
        chk("fl_no_emit", OutValid, 0);

        // Flush in ONE drops the held entry and the same-cycle push.
        OutReady = 1'b0; InValid = 1'b1; AluResult = `XLEN'(4);
        cycle();
        chk("fl1_one", OutValid, 1);
        Flush = 1'b1; AluResult = `XLEN'(5);
        cycle();
        Flush = 1'b0; InValid = 1'b0; OutReady = 1'b1;
        chk("fl1_valid", OutValid, 0);
        cycle();
        chk("fl1_no_emit", OutValid, 0);

        // Asynchronous reset while FULL.
        fill2(`XLEN'(6), `XLEN'(7));
        reset_n = 1'b0;
        #1;
        chk("ar_valid", OutValid, 0);
        chk("ar_ready", InReady, 1);
        chk("ar_rw", OutRegWrite, 0);
        chk("ar_result", OutResult, 0);
        @(negedge clk);
        reset_n = 1'b1;
        InValid = 1'b1; AluResult = `XLEN'('h5);
        cycle();
        InValid = 1'b0; OutReady = 1'b1;
        chk("ar_push_result", OutResult, 'h5);
        chk("ar_push_valid", OutValid, 1);
        cycle();
        chk("ar_drained", OutValid, 0);

        // Branch vector table.
        OutReady = 1'b1; InRegWrite = 1'b1;
        for (int i = 0; i < 9; i++) begin
            InValid = 1'b1; InIsBranch = tbl[i].isb; InBranchOp = branchOperation'(tbl[i].op);
            Zero = tbl[i].z; oVerflow = tbl[i].v; Negative = tbl[i].n; Carry = tbl[i].c;
            AluResult = `XLEN'(tbl[i].data); InRd = RDW'(i);
            cycle();
            InValid = 1'b0; InIsBranch = 1'b0;
            Zero = 1'b0; oVerflow = 1'b0; Negative = 1'b0; Carry = 1'b0;
`ifdef BRANCH_EVAL_EN
            chk($sformatf("br_taken_%0d", i), OutBranchTaken, tbl[i].taken_on);
`else
            chk($sformatf("br_taken_%0d", i), OutBranchTaken, 0);
`endif
            chk($sformatf("br_data_%0d", i), OutResult, tbl[i].data);
            cycle();
            chk($sformatf("br_clear_%0d", i), OutBranchTaken, 0);
        end

        // Randomized traffic against the queue model.
        q.delete();
        for (int i = 0; i < 600; i++) begin
            entry_t e;
            logic do_push, do_pop, fl;
            InValid    = ($urandom_range(0, 3) != 0);
            AluResult  = `XLEN'($urandom);
            InRd       = RDW'($urandom);
            InRegWrite = 1'($urandom_range(0, 1));
            InIsBranch = 1'($urandom_range(0, 1));
            InBranchOp = branchOperation'(3'($urandom_range(0, 7)));
            Zero       = 1'($urandom_range(0, 1));
            oVerflow   = 1'($urandom_range(0, 1));
            Negative   = 1'($urandom_range(0, 1));
            Carry      = 1'($urandom_range(0, 1));
            OutReady   = ($urandom_range(0, 2) != 0);
            Flush      = ($urandom_range(0, 15) == 0);

            chk("rnd_valid", OutValid, q.size() > 0);
            chk("rnd_ready", InReady, q.size() < 2);
            if (q.size() > 0) begin
                chk("rnd_result", OutResult, q[0].result);
                chk("rnd_rd", OutRd, q[0].rd);
                chk("rnd_rw", OutRegWrite, q[0].rw);
                chk("rnd_taken", OutBranchTaken, q[0].taken);
            end else begin
                chk("rnd_idle_rw", OutRegWrite, 0);
                chk("rnd_idle_taken", OutBranchTaken, 0);
            end

            fl      = Flush;
            do_push = InValid && (q.size() < 2) && !fl;
            do_pop  = (q.size() > 0) && OutReady && !fl;
            e.result = AluResult;
            e.rd     = InRd;
            e.rw     = InRegWrite;
            e.taken  = model_taken(InIsBranch, InBranchOp, Zero, oVerflow, Negative, Carry);
            cycle();
            if (fl) q.delete();
            else begin
                if (do_pop) void'(q.pop_front());
                if (do_push) q.push_back(e);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/execute_result_buffer.md
EXECUTE_RESULT_BUFFER -- requirements
Module: execute_result_buffer

Interface
REQ-001 SHALL have parameter RD_WIDTH, default 5: destination register index width.
REQ-002 SHALL take data width from `XLEN (parameters.svh); no data-width parameter.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 InValid  input  1  upstream ALU result valid.
REQ-006 InReady  output  1  buffer can accept an entry this cycle.
REQ-007 AluResult  input  XLEN  ALU result.
REQ-008 Zero, oVerflow, Negative, Carry  input  1 each  ALU flags; Carry=1 means unsigned borrow on SUB.
REQ-009 InRd  input  RD_WIDTH; InRegWrite  input  1; InIsBranch  input  1; InBranchOp  input  HighLevelControl::branchOperation.
REQ-010 Flush  input  1  discard all held and incoming entries.
REQ-011 OutValid  output  1; OutReady  input  1  downstream accepts when both high.
REQ-012 OutResult  output  XLEN; OutRd  output  RD_WIDTH; OutRegWrite  output  1; OutBranchTaken  output  1.

Function
REQ-013 SHALL be a 2-entry skid buffer, FIFO order, states EMPTY, ONE, FULL.
REQ-014 Push = InValid & InReady & ~Flush; pop = OutValid & OutReady & ~Flush.
REQ-015 InReady SHALL be registered: high in EMPTY and ONE, low in FULL.
REQ-016 Transitions: EMPTY+push->ONE; ONE+push&~pop->FULL; ONE+pop&~push->EMPTY; ONE+push&pop->ONE; FULL+pop->ONE; otherwise hold.
REQ-017 Latency: entry pushed in cycle N SHALL appear on outputs with OutValid=1 in cycle N+1; no combinational path from In* to Out*.
REQ-018 OutValid SHALL be high exactly in ONE and FULL; Out* SHALL show the oldest entry and remain stable while OutValid & ~OutReady.
REQ-019 Branch taken SHALL be computed at push from the flags and stored with the entry: BEQ Zero; BNE ~Zero; BLT Negative^oVerflow; BGE ~(Negative^oVerflow); BLTU Carry; BGEU ~Carry.
REQ-020 OutBranchTaken SHALL be 0 for entries pushed with InIsBranch=0, or with an undefined InBranchOp.
REQ-021 OutResult SHALL carry AluResult bit-exact; no width change.
REQ-022 Flush SHALL force EMPTY next cycle, discard both entries and any same-cycle push, and take priority over push and pop.
REQ-023 InValid while FULL SHALL not be accepted; upstream holds its data.
REQ-024 Out* data when OutValid=0 SHALL be don't-care, except OutRegWrite and OutBranchTaken, which SHALL be 0.

Reset
REQ-025 reset_n low SHALL immediately force EMPTY, InReady=1, OutValid=0, OutRegWrite=0, OutBranchTaken=0, OutResult=0, OutRd=0.
REQ-026 Reset mid-operation SHALL discard all entries; first push after reset_n rises behaves as from EMPTY.

Configuration
REQ-027 Macro BRANCH_EVAL_EN: when defined, REQ-019/020 apply.
REQ-028 When BRANCH_EVAL_EN is undefined, InIsBranch and InBranchOp SHALL be ignored, no branch storage synthesized, OutBranchTaken tied 0.

Structure
REQ-029 branchOperation enum (BEQ, BNE, BLT, BGE, BLTU, BGEU) and bufferState enum (EMPTY, ONE, FULL) SHALL live in package HighLevelControl.
REQ-030 Branch condition logic SHALL be sub-module branchEvaluator (combinational; flags + branchOperation -> taken), instantiated only under BRANCH_EVAL_EN.

Verification
REQ-031 Reset: reset_n=0 mid-FULL -> same cycle OutValid=0, InReady=1; after release, push 0x5 -> OutResult=0x5 next cycle.
REQ-032 Backpressure: OutReady=0, push 0xA then 0xB -> FULL, InReady=0, third InValid ignored; OutReady=1 -> 0xA then 0xB in order.
REQ-033 Streaming: OutReady=1, push every cycle 1..8 -> state stays ONE, outputs 1..8 one cycle delayed, no bubbles.
REQ-034 Branch: InIsBranch=1, BLT, Negative=1, oVerflow=1 -> OutBranchTaken=0; BLTU, Carry=1 -> 1; BNE, Zero=1 -> 0.
REQ-035 Flush: FULL, Flush=1 with InValid=1 -> next cycle EMPTY, OutValid=0, pushed entry never emitted.
REQ-036 Macro off: same stimulus as REQ-034 -> OutBranchTaken always 0; data path unchanged.
